// File: rtl/uart_host_seq.sv
// uart_host_seq: register-bus initiator for the UART core slave port.
// Programs BAUD and RX_EN after reset, packs host TX bytes into bursts,
// launches each burst and waits for completion, and drains the RX FIFO
// into a valid/ready stream. Every reg_* output is a registered single-cycle access.
module uart_host_seq #(
    parameter logic [15:0] BAUD_DIV   = 16'd868,
    parameter int          BURST      = 7,
    parameter logic [15:0] TX_TIMEOUT = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tx_valid_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_last_i,
    output logic        tx_ready_o,
    output logic        rx_valid_o,
    output logic [7:0]  rx_data_o,
    input  logic        rx_ready_i,
    output logic        reg_we_o,
    output logic        reg_re_o,
    output logic [11:0] reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic [31:0] reg_rdata_i,
    input  logic        tx_done_i,
    input  logic        rx_empty_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [11:0] ADDR_BAUD    = 12'h000;
    localparam logic [11:0] ADDR_TX_DATA = 12'h004;
    localparam logic [11:0] ADDR_RX_DATA = 12'h008;
    localparam logic [11:0] ADDR_RX_EN   = 12'h00C;
    localparam logic [11:0] ADDR_TX_LVL  = 12'h018;
    localparam logic [11:0] ADDR_RD_EN   = 12'h01C;
    localparam logic [2:0]  BURST_C      = 3'(BURST);

    // state      | meaning
    // INIT_BAUD  | reset state; BAUD write is issued on leaving
    // INIT_RX    | BAUD on the bus; RX_EN write issued on leaving
    // IDLE       | accept first TX byte or start an RX read
    // TX_FILL    | TX_DATA writes, further bytes accepted until burst closes
    // TX_LEVEL   | TX_FIFO_LEVEL write on the bus
    // TX_GO      | RD_EN_TXFIFO=1 write on the bus
    // TX_WAIT    | waiting for tx_done_i or timeout
    // TX_STOP    | RD_EN_TXFIFO=0 write on the bus
    // RX_RD      | RX_DATA read strobe on the bus
    // RX_CAP     | read data returning; captured on leaving
    typedef enum logic [3:0] {
        INIT_BAUD, INIT_RX, IDLE, TX_FILL, TX_LEVEL,
        TX_GO, TX_WAIT, TX_STOP, RX_RD, RX_CAP
    } state_t;

    state_t      state;
    logic [2:0]  count;
    logic        closed;
    logic [15:0] wait_cnt;

    logic        close_now;
    logic [2:0]  count_inc;

    // A byte closes the burst when it carries tx_last_i or fills it to BURST.
    always_comb begin
        count_inc = count + 3'd1;
        close_now = 1'b0;
        if (state == IDLE) begin
            close_now = tx_last_i || (BURST_C == 3'd1);
        end else begin
            close_now = tx_last_i || (count_inc == BURST_C);
        end
    end

    // Sequencer: state, counters and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= INIT_BAUD;
            count       <= 3'd0;
            closed      <= 1'b0;
            wait_cnt    <= 16'd0;
            tx_ready_o  <= 1'b0;
            rx_valid_o  <= 1'b0;
            rx_data_o   <= 8'd0;
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            reg_addr_o  <= 12'd0;
            reg_wdata_o <= 32'd0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            reg_we_o    <= 1'b0;
            reg_re_o    <= 1'b0;
            reg_addr_o  <= 12'd0;
            reg_wdata_o <= 32'd0;
            busy_o      <= (state != IDLE);
            if (rx_valid_o && rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end
            case (state)
                INIT_BAUD: begin
                    reg_we_o    <= 1'b1;
                    reg_addr_o  <= ADDR_BAUD;
                    reg_wdata_o <= {16'd0, BAUD_DIV};
                    state       <= INIT_RX;
                end
                INIT_RX: begin
                    reg_we_o    <= 1'b1;
                    reg_addr_o  <= ADDR_RX_EN;
                    reg_wdata_o <= 32'd1;
                    state       <= IDLE;
                end
                IDLE: begin
                    // A handshake already offered by tx_ready_o is honoured first.
                    if (tx_valid_i && tx_ready_o) begin
                        reg_we_o    <= 1'b1;
                        reg_addr_o  <= ADDR_TX_DATA;
                        reg_wdata_o <= {24'd0, tx_data_i};
                        count       <= 3'd1;
                        closed      <= close_now;
                        tx_ready_o  <= !close_now;
                        busy_o      <= 1'b1;
                        state       <= TX_FILL;
                    end else if (!rx_empty_i && !rx_valid_o) begin
                        reg_re_o    <= 1'b1;
                        reg_addr_o  <= ADDR_RX_DATA;
                        tx_ready_o  <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= RX_RD;
                    end else begin
                        tx_ready_o  <= 1'b1;
                    end
                end
                TX_FILL: begin
                    if (closed) begin
                        reg_we_o    <= 1'b1;
                        reg_addr_o  <= ADDR_TX_LVL;
                        reg_wdata_o <= {29'd0, count};
                        tx_ready_o  <= 1'b0;
                        state       <= TX_LEVEL;
                    end else if (tx_valid_i && tx_ready_o) begin
                        reg_we_o    <= 1'b1;
                        reg_addr_o  <= ADDR_TX_DATA;
                        reg_wdata_o <= {24'd0, tx_data_i};
                        count       <= count_inc;
                        closed      <= close_now;
                        tx_ready_o  <= !close_now;
                    end
                end
                TX_LEVEL: begin
                    reg_we_o    <= 1'b1;
                    reg_addr_o  <= ADDR_RD_EN;
                    reg_wdata_o <= 32'd1;
                    wait_cnt    <= 16'd0;
                    state       <= TX_GO;
                end
                TX_GO: begin
                    state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done_i || (wait_cnt >= TX_TIMEOUT - 16'd1)) begin
                        if (!tx_done_i) begin
                            err_o <= 1'b1;
                        end
                        reg_we_o    <= 1'b1;
                        reg_addr_o  <= ADDR_RD_EN;
                        reg_wdata_o <= 32'd0;
                        state       <= TX_STOP;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                TX_STOP: begin
                    count  <= 3'd0;
                    closed <= 1'b0;
                    state  <= IDLE;
                end
                RX_RD: begin
                    state <= RX_CAP;
                end
                RX_CAP: begin
                    rx_data_o  <= reg_rdata_i[7:0];
                    rx_valid_o <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= INIT_BAUD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host_seq.sv
// Directed testbench for uart_host_seq: init sequence, TX bursts,
// RX backpressure, TX timeout and reset during a burst.
module tb_uart_host_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'd0;
    logic        tx_last = 1'b0;
    logic        tx_ready_o;
    logic        rx_valid_o;
    logic [7:0]  rx_data_o;
    logic        rx_ready = 1'b0;
    logic        reg_we_o;
    logic        reg_re_o;
    logic [11:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] reg_rdata = 32'd0;
    logic        tx_done = 1'b0;
    logic        rx_empty = 1'b1;
    logic        busy_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;

    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          rd_cnt = 0;

    wire [45:0] bus = {reg_we_o, reg_re_o, reg_addr_o, reg_wdata_o};

    uart_host_seq #(
        .BAUD_DIV(16'd868),
        .BURST(7),
        .TX_TIMEOUT(16'd20)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .tx_valid_i(tx_valid),
        .tx_data_i(tx_data),
        .tx_last_i(tx_last),
        .tx_ready_o(tx_ready_o),
        .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o),
        .rx_ready_i(rx_ready),
        .reg_we_o(reg_we_o),
        .reg_re_o(reg_re_o),
        .reg_addr_o(reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_rdata_i(reg_rdata),
        .tx_done_i(tx_done),
        .rx_empty_i(rx_empty),
        .busy_o(busy_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Bus recorder: logs every write and counts reads.
    always @(negedge clk) begin
        if (!rst && reg_we_o) begin
            wa_q.push_back(reg_addr_o);
            wd_q.push_back(reg_wdata_o);
        end
        if (!rst && reg_re_o) rd_cnt = rd_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!(tx_ready_o === 1'b1 && busy_o === 1'b0) && n < 60) begin
            step();
            n++;
        end
        vectors++;
        if (!(tx_ready_o === 1'b1 && busy_o === 1'b0)) begin
            miscompares++;
            $display("FAIL %s_ready: tx_ready=%b busy=%b after %0d cycles, want 1/0", tag, tx_ready_o, busy_o, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_done = 1'b0;
        rx_empty = 1'b1; rx_ready = 1'b0;
        step();
        vectors++;
        if ({bus, tx_ready_o, rx_valid_o, rx_data_o, busy_o, err_o} !== 58'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: bus=%h rdy=%b rxv=%b rxd=%h busy=%b err=%b, want all 0",
                     bus, tx_ready_o, rx_valid_o, rx_data_o, busy_o, err_o);
        end
        step();
        rst = 1'b0;
        step();
        vectors++;
        if (bus !== {2'b10, 12'h000, 32'h364} || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL init_baud: bus=%h busy=%b, want %h busy=1", bus, busy_o, {2'b10, 12'h000, 32'h364});
        end
        step();
        vectors++;
        if (bus !== {2'b10, 12'h00C, 32'h1} || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL init_rx_en: bus=%h busy=%b, want %h busy=1", bus, busy_o, {2'b10, 12'h00C, 32'h1});
        end
        step();
        vectors++;
        if (bus !== 46'd0 || busy_o !== 1'b0 || tx_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL init_done: bus=%h busy=%b rdy=%b, want 0 0 1", bus, busy_o, tx_ready_o);
        end
    endtask

    task automatic test_burst3();
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tx_valid = 1'b1; tx_data = bytes[i]; tx_last = (i == 2);
            step();
            vectors++;
            if (bus !== {2'b10, 12'h004, 24'd0, bytes[i]} || tx_ready_o !== (i != 2)) begin
                miscompares++;
                $display("FAIL burst3_data%0d: bus=%h rdy=%b, want %h rdy=%b", i, bus, tx_ready_o,
                         {2'b10, 12'h004, 24'd0, bytes[i]}, (i != 2));
            end
        end
        tx_valid = 1'b0; tx_last = 1'b0;
        step();
        vectors++;
        if (bus !== {2'b10, 12'h018, 32'd3}) begin
            miscompares++;
            $display("FAIL burst3_level: bus=%h, want %h", bus, {2'b10, 12'h018, 32'd3});
        end
        step();
        vectors++;
        if (bus !== {2'b10, 12'h01C, 32'd1}) begin
            miscompares++;
            $display("FAIL burst3_go: bus=%h, want %h", bus, {2'b10, 12'h01C, 32'd1});
        end
        step();
        vectors++;
        if (bus !== 46'd0 || busy_o !== 1'b1 || tx_ready_o !== 1'b0) begin
            miscompares++;
            $display("FAIL burst3_wait: bus=%h busy=%b rdy=%b, want 0 1 0", bus, busy_o, tx_ready_o);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        vectors++;
        if (bus !== {2'b10, 12'h01C, 32'd0}) begin
            miscompares++;
            $display("FAIL burst3_stop: bus=%h, want %h", bus, {2'b10, 12'h01C, 32'd0});
        end
        wait_ready("burst3");
    endtask

    task automatic test_stream10();
        int base = wa_q.size();
        logic [11:0] exp_a [16];
        logic [31:0] exp_d [16];
        int stall;
        for (int i = 0; i < 10; i++) begin
            if (i == 9) begin
                tx_valid = 1'b0;
                step(); step(); step();
                vectors++;
                if (tx_ready_o !== 1'b1 || bus !== 46'd0) begin
                    miscompares++;
                    $display("FAIL stream_open_burst: rdy=%b bus=%h, want rdy=1 bus=0", tx_ready_o, bus);
                end
            end
            tx_valid = 1'b1; tx_data = 8'h40 + 8'(i); tx_last = (i == 9);
            stall = 0;
            while (tx_ready_o !== 1'b1 && stall < 40) begin
                step();
                stall++;
                tx_done = 1'b0;
                if (stall == 8) begin
                    vectors++;
                    if (tx_ready_o !== 1'b0 || busy_o !== 1'b1 || bus !== 46'd0) begin
                        miscompares++;
                        $display("FAIL stream_wait_hold: rdy=%b busy=%b bus=%h, want 0 1 0", tx_ready_o, busy_o, bus);
                    end
                    tx_done = 1'b1;
                end
            end
            if (stall >= 40) begin
                vectors++;
                miscompares++;
                $display("FAIL stream_accept_timeout: byte %0d rdy=%b, want 1 within 40 cycles", i, tx_ready_o);
            end
            step();
        end
        tx_valid = 1'b0; tx_last = 1'b0;
        tx_done = 1'b1;
        wait_ready("stream");
        tx_done = 1'b0;
        for (int i = 0; i < 7; i++) begin
            exp_a[i] = 12'h004; exp_d[i] = 32'h40 + 32'(i);
        end
        exp_a[7] = 12'h018; exp_d[7] = 32'd7;
        exp_a[8] = 12'h01C; exp_d[8] = 32'd1;
        exp_a[9] = 12'h01C; exp_d[9] = 32'd0;
        for (int i = 0; i < 3; i++) begin
            exp_a[10 + i] = 12'h004; exp_d[10 + i] = 32'h47 + 32'(i);
        end
        exp_a[13] = 12'h018; exp_d[13] = 32'd3;
        exp_a[14] = 12'h01C; exp_d[14] = 32'd1;
        exp_a[15] = 12'h01C; exp_d[15] = 32'd0;
        vectors++;
        if (wa_q.size() - base !== 16) begin
            miscompares++;
            $display("FAIL stream_write_count: got %0d writes, want 16", wa_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                vectors++;
                if (wa_q[base + i] !== exp_a[i] || wd_q[base + i] !== exp_d[i]) begin
                    miscompares++;
                    $display("FAIL stream_write%0d: got %h/%h, want %h/%h", i,
                             wa_q[base + i], wd_q[base + i], exp_a[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_rx();
        int rd_base = rd_cnt;
        rx_empty = 1'b0; rx_ready = 1'b0;
        reg_rdata = 32'hFFFF_FFA5;
        step();
        vectors++;
        if (bus !== {2'b01, 12'h008, 32'd0}) begin
            miscompares++;
            $display("FAIL rx_strobe1: bus=%h, want %h", bus, {2'b01, 12'h008, 32'd0});
        end
        step();
        step();
        vectors++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5) begin
            miscompares++;
            $display("FAIL rx_first: valid=%b data=%h, want 1 a5", rx_valid_o, rx_data_o);
        end
        reg_rdata = 32'h0000_005A;
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'hA5 || rd_cnt - rd_base !== 1) begin
            miscompares++;
            $display("FAIL rx_backpressure: valid=%b data=%h reads=%0d, want 1 a5 1", rx_valid_o, rx_data_o, rd_cnt - rd_base);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        vectors++;
        if (rx_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rx_handshake1: valid=%b, want 0", rx_valid_o);
        end
        step();
        vectors++;
        if (bus !== {2'b01, 12'h008, 32'd0}) begin
            miscompares++;
            $display("FAIL rx_strobe2: bus=%h, want %h", bus, {2'b01, 12'h008, 32'd0});
        end
        rx_empty = 1'b1;
        step();
        step();
        vectors++;
        if (rx_valid_o !== 1'b1 || rx_data_o !== 8'h5A || rd_cnt - rd_base !== 2) begin
            miscompares++;
            $display("FAIL rx_second: valid=%b data=%h reads=%0d, want 1 5a 2", rx_valid_o, rx_data_o, rd_cnt - rd_base);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        vectors++;
        if (rx_valid_o !== 1'b0 || rx_data_o !== 8'h5A) begin
            miscompares++;
            $display("FAIL rx_handshake2: valid=%b data=%h, want 0 5a", rx_valid_o, rx_data_o);
        end
        wait_ready("rx");
    endtask

    task automatic test_timeout();
        tx_valid = 1'b1; tx_data = 8'h77; tx_last = 1'b1;
        step();
        tx_valid = 1'b0; tx_last = 1'b0;
        step(); step(); step();
        for (int i = 0; i < 19; i++) step();
        vectors++;
        if (err_o !== 1'b0 || bus !== 46'd0 || busy_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: err=%b bus=%h busy=%b, want 0 0 1", err_o, bus, busy_o);
        end
        step();
        vectors++;
        if (err_o !== 1'b1 || bus !== {2'b10, 12'h01C, 32'd0}) begin
            miscompares++;
            $display("FAIL timeout_fire: err=%b bus=%h, want 1 %h", err_o, bus, {2'b10, 12'h01C, 32'd0});
        end
        wait_ready("timeout");
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (err_o !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_sticky: err=%b, want 1", err_o);
        end
    endtask

    task automatic test_reset_mid();
        tx_valid = 1'b1; tx_data = 8'h81; tx_last = 1'b0;
        step();
        tx_data = 8'h82;
        step();
        tx_valid = 1'b0;
        test_reset();
        tx_valid = 1'b1; tx_data = 8'h99; tx_last = 1'b1;
        step();
        tx_valid = 1'b0; tx_last = 1'b0;
        step();
        vectors++;
        if (bus !== {2'b10, 12'h018, 32'd1} || err_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_level: bus=%h err=%b, want %h err=0", bus, err_o, {2'b10, 12'h018, 32'd1});
        end
        tx_done = 1'b1;
        wait_ready("reset_mid");
        tx_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_burst3();
        test_stream10();
        test_rx();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
